// File: rtl/minisys_fetch_queue.sv
// minisys_fetch_queue: instruction buffer plus IF/ID register for the Minisys-1A pipeline.
// Buffers {instrF, pcplus4F} in a small FIFO and feeds decode with registered instrD/pcplus4D/validD.
//
// Ports:
//   clk       - system clock, all state updates on the rising edge
//   rst       - synchronous reset, active-high
//   instrF    - fetched instruction
//   pcplus4F  - PC+4 of instrF
//   validF    - instrF/pcplus4F valid this cycle
//   readyF    - queue can accept (push = validF & readyF)
//   load_use  - decode stall request, holds the ID register
//   branchM   - taken branch resolved in MEM, flushes everything
//   jumpI     - jump resolved in ID, flushes everything
//   instrD    - instruction presented to decode (registered)
//   pcplus4D  - PC+4 of instrD (registered)
//   validD    - instrD is a real instruction, 0 = bubble
//   count     - FIFO occupancy, excluding the ID register
module minisys_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             instrF,
    input  logic [WIDTH-1:0]             pcplus4F,
    input  logic                         validF,
    output logic                         readyF,
    input  logic                         load_use,
    input  logic                         branchM,
    input  logic                         jumpI,
    output logic [WIDTH-1:0]             instrD,
    output logic [WIDTH-1:0]             pcplus4D,
    output logic                         validD,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] instrD_q, instrD_d;
    logic [WIDTH-1:0] pcD_q, pcD_d;
    logic             validD_q, validD_d;

    logic             flush;
    logic             push;
    logic             we;

    // Full is judged from the occupancy counter; a pop in the same
    // cycle does not open a slot for the incoming instruction.
    assign readyF = !rst && (count_q != FULL);
    assign push   = validF && readyF;
    assign flush  = branchM || jumpI;

    always_comb begin
        wr_d     = wr_q;
        rd_d     = rd_q;
        count_d  = count_q;
        instrD_d = instrD_q;
        pcD_d    = pcD_q;
        validD_d = validD_q;
        we       = 1'b0;

        if (flush) begin
            wr_d     = '0;
            rd_d     = '0;
            count_d  = '0;
            instrD_d = '0;
            pcD_d    = '0;
            validD_d = 1'b0;
        end else if (load_use) begin
            if (push) begin
                we      = 1'b1;
                wr_d    = wr_q + 1'b1;
                count_d = count_q + 1'b1;
            end
        end else if (count_q != '0) begin
            instrD_d = instr_mem_q[rd_q];
            pcD_d    = pc_mem_q[rd_q];
            validD_d = 1'b1;
            rd_d     = rd_q + 1'b1;
            if (push) begin
                we   = 1'b1;
                wr_d = wr_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end else if (push) begin
            // Empty queue: fetch output goes straight into the ID register.
            instrD_d = instrF;
            pcD_d    = pcplus4F;
            validD_d = 1'b1;
        end else begin
            instrD_d = '0;
            validD_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            instrD_q <= '0;
            pcD_q    <= '0;
            validD_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            instrD_q <= instrD_d;
            pcD_q    <= pcD_d;
            validD_q <= validD_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (we) begin
            instr_mem_q[wr_q] <= instrF;
            pc_mem_q[wr_q]    <= pcplus4F;
        end
    end

    assign instrD   = instrD_q;
    assign pcplus4D = pcD_q;
    assign validD   = validD_q;
    assign count    = count_q;

endmodule
